msrv32_wb_port_arbiter: RTL and testbench
=========================================

Name: msrv32_wb_port_arbiter

Overview:
- Owns the single register-file write port.
- Arbitrates between the in-order pipeline writeback (the output of the writeback mux) and out-of-band load responses returning from data memory.
- Tracks outstanding load destinations in an in-order queue and flags read-after-write hazards against them.
- Sits between the writeback mux select unit / load unit and the integer register file.

Parameters:
- LD_DEPTH, 2, number of outstanding loads tracked. Power of two, 2..8.
- PTR_W, $clog2(LD_DEPTH), queue pointer width. Derived; not overridden.

Ports:
- ms_riscv32_mp_clk_in  in  1  core clock
- ms_riscv32_mp_rst_in  in  1  asynchronous reset, active-high
- pipe_wr_req_in  in  1  pipeline writeback request
- pipe_rd_addr_in  in  5  pipeline destination register
- pipe_wb_data_in  in  32  writeback mux output
- pipe_stall_out  out  1  pipeline request not accepted this cycle; source holds request
- ld_issue_in  in  1  load issued; push destination
- ld_rd_addr_in  in  5  load destination register
- ld_rsp_valid_in  in  1  load data returned (in issue order); cannot be back-pressured
- ld_rsp_data_in  in  32  aligned/extended load data
- ld_full_out  out  1  queue full
- ld_empty_out  out  1  queue empty
- rs1_addr_in  in  5  decode-stage source 1
- rs2_addr_in  in  5  decode-stage source 2
- hazard_out  out  1  rs1/rs2 matches a pending load destination
- rf_wr_en_out  out  1  register-file write enable (registered)
- rf_rd_addr_out  out  5  register-file write address (registered)
- rf_wr_data_out  out  32  register-file write data (registered)
- ld_overflow_out  out  1  sticky: issue while full without a pop
- ld_underflow_out  out  1  sticky: response while empty
- fwd_valid_out  out  1  forwarding valid (see Optional Feature)
- fwd_addr_out  out  5  forwarding register
- fwd_data_out  out  32  forwarding data

Behaviour:
- Reset (async, active-high):
  - rf_wr_en_out=0, rf_rd_addr_out=0, rf_wr_data_out=0.
  - Skid buffer empty, so pipe_stall_out=0.
  - Queue empty: ld_empty_out=1, ld_full_out=0, hazard_out=0.
  - Sticky flags cleared. fwd_* outputs = 0.
  - Reset mid-operation discards all pending loads and skid contents.
- Write port source priority per cycle:
  1. Load response (queue head destination, ld_rsp_data_in).
  2. Skid buffer.
  3. New pipeline request.
- The winner's address and data are registered; rf_wr_en_out rises the next cycle. Latency is 1 cycle from request/response to write.
- Acceptance:
  - pipe_stall_out = skid_valid (combinational from state).
  - A pipeline request is accepted when pipe_wr_req_in=1 and pipe_stall_out=0.
  - If it is accepted in the same cycle as a load response, it is captured into the 1-entry skid and written the following cycle; pipe_stall_out is high that following cycle.
  - If a load response arrives while the skid is valid, the response wins and the skid holds one more cycle.
- x0: any winning write to rd=0 drives rf_wr_en_out=0 that cycle, but still consumes its slot. A load with rd=0 is still queued to preserve ordering.
- Queue:
  - Circular, in-order, with PTR_W+1-bit pointers.
  - Push on ld_issue_in; pop on ld_rsp_valid_in.
  - Push and pop in the same cycle are legal at any occupancy, including full: occupancy is unchanged and the popped entry is the old head.
  - Push when full with no pop: ignored; ld_overflow_out set.
  - Response when empty: no write; ld_underflow_out set.
  - ld_full_out and ld_empty_out are derived from the registered pointers.
  - Sticky flags clear only on reset.
- Hazard: hazard_out is combinational. It is 1 if any valid queue entry has rd != 0 and rd equal to rs1_addr_in or rs2_addr_in. Entries pushed in the current cycle are not yet included.

Optional Feature:
- Macro: MSRV32_WB_FWD_EN.
- Defined: in a load-response cycle, fwd_valid_out=1 (only if the head rd != 0), fwd_addr_out = head rd, fwd_data_out = ld_rsp_data_in, all combinational. Also, hazard_out excludes the popped head entry, so the hazard releases one cycle earlier.
- Undefined: fwd_* are tied to 0, and hazard_out includes the head entry until the pop is registered.

Test Plan:
- Reset, then pipe req rd=5 data 0x12345678 → next cycle rf_wr_en=1, addr=5, data=0x12345678; pipe_stall stays 0.
- ld_issue rd=7, then pipe req rd=3 (0xABCDEFAB) in the same cycle as ld_rsp 0x87654321:
  - cycle+1: write rd=7 with 0x87654321, pipe_stall=1.
  - cycle+2: write rd=3 with 0xABCDEFAB, pipe_stall=0.
- Issue two loads (rd=1, rd=2) → ld_full=1. Third issue with no response → ignored, ld_overflow=1. Responses 0x11 then 0x22 → writes rd1=0x11 then rd2=0x22, ld_empty=1.
- Pending load rd=9 with rs2_addr=9 → hazard_out=1. rs1=rs2=0 → 0. After the response is written → 0.
- Pipe req rd=0 (0xFFFFFFFF) → rf_wr_en stays 0. Response with an empty queue → no write, ld_underflow=1.
- Assert reset with two loads pending and the skid full → all outputs at reset values, ld_empty=1. With MSRV32_WB_FWD_EN, a response for rd=4 with 0x98765432 → same-cycle fwd_valid=1, addr=4, data=0x98765432.

Source files
------------

// File: rtl/msrv32_wb_port_arbiter.sv
// Register-file write-port arbiter: load responses > skid buffer > pipeline writeback,
// with an in-order pending-load queue and RAW hazard detection. Optional macro: MSRV32_WB_FWD_EN.
module msrv32_wb_port_arbiter #(
  parameter int LD_DEPTH = 2,
  parameter int PTR_W    = $clog2(LD_DEPTH)
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  input  logic        pipe_wr_req_in,
  input  logic [4:0]  pipe_rd_addr_in,
  input  logic [31:0] pipe_wb_data_in,
  output logic        pipe_stall_out,
  input  logic        ld_issue_in,
  input  logic [4:0]  ld_rd_addr_in,
  input  logic        ld_rsp_valid_in,
  input  logic [31:0] ld_rsp_data_in,
  output logic        ld_full_out,
  output logic        ld_empty_out,
  input  logic [4:0]  rs1_addr_in,
  input  logic [4:0]  rs2_addr_in,
  output logic        hazard_out,
  output logic        rf_wr_en_out,
  output logic [4:0]  rf_rd_addr_out,
  output logic [31:0] rf_wr_data_out,
  output logic        ld_overflow_out,
  output logic        ld_underflow_out,
  output logic        fwd_valid_out,
  output logic [4:0]  fwd_addr_out,
  output logic [31:0] fwd_data_out
);

  logic [PTR_W:0]   wr_ptr, rd_ptr, count;
  logic [4:0]       ld_rd_q [LD_DEPTH];
  logic             q_empty, q_full, push, pop, accept;
  logic [4:0]       head_rd;
  logic             skid_valid;
  logic [4:0]       skid_addr;
  logic [31:0]      skid_data;
  logic             win_vld_p0;
  logic [4:0]       win_addr_p0;
  logic [31:0]      win_data_p0;
  logic             vld_p1;
  logic [4:0]       addr_p1;
  logic [31:0]      data_p1;
  logic [PTR_W-1:0] offset;
  logic             in_q;

  assign q_empty = (wr_ptr == rd_ptr);
  assign q_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign head_rd = ld_rd_q[rd_ptr[PTR_W-1:0]];
  // A pop frees a slot in the same cycle, so a push at full is still taken.
  assign pop     = ld_rsp_valid_in & ~q_empty;
  assign push    = ld_issue_in & (~q_full | pop);
  assign accept  = pipe_wr_req_in & ~skid_valid;

  assign pipe_stall_out = skid_valid;
  assign ld_full_out    = q_full;
  assign ld_empty_out   = q_empty;

  always_comb begin
    hazard_out = 1'b0;
    offset     = '0;
    in_q       = 1'b0;
    for (int i = 0; i < LD_DEPTH; i++) begin
      offset = PTR_W'(i) - rd_ptr[PTR_W-1:0];
      in_q   = ({1'b0, offset} < count);
`ifdef MSRV32_WB_FWD_EN
      if (pop && (offset == '0)) in_q = 1'b0;
`endif
      if (in_q && (ld_rd_q[i] != 5'd0) &&
          ((ld_rd_q[i] == rs1_addr_in) || (ld_rd_q[i] == rs2_addr_in)))
        hazard_out = 1'b1;
    end
  end

  always_comb begin
    win_vld_p0  = 1'b0;
    win_addr_p0 = skid_addr;
    win_data_p0 = skid_data;
    if (pop) begin
      win_vld_p0  = 1'b1;
      win_addr_p0 = head_rd;
      win_data_p0 = ld_rsp_data_in;
    end else if (skid_valid) begin
      win_vld_p0  = 1'b1;
    end else if (accept) begin
      win_vld_p0  = 1'b1;
      win_addr_p0 = pipe_rd_addr_in;
      win_data_p0 = pipe_wb_data_in;
    end
  end

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (push) ld_rd_q[wr_ptr[PTR_W-1:0]] <= ld_rd_addr_in;
    if (pop && accept) begin
      skid_addr <= pipe_rd_addr_in;
      skid_data <= pipe_wb_data_in;
    end
  end

  // p0 -> p1: winner registered onto the write port; x0 writes keep their slot but drop the enable.
  always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
    if (ms_riscv32_mp_rst_in) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      skid_valid       <= 1'b0;
      vld_p1           <= 1'b0;
      addr_p1          <= 5'd0;
      data_p1          <= 32'd0;
      ld_overflow_out  <= 1'b0;
      ld_underflow_out <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
      if (pop && accept)          skid_valid <= 1'b1;
      else if (!pop && skid_valid) skid_valid <= 1'b0;
      vld_p1 <= win_vld_p0 && (win_addr_p0 != 5'd0);
      if (win_vld_p0) begin
        addr_p1 <= win_addr_p0;
        data_p1 <= win_data_p0;
      end
      if (ld_issue_in && q_full && !pop)   ld_overflow_out  <= 1'b1;
      if (ld_rsp_valid_in && q_empty)      ld_underflow_out <= 1'b1;
    end
  end

  assign rf_wr_en_out   = vld_p1;
  assign rf_rd_addr_out = addr_p1;
  assign rf_wr_data_out = data_p1;

`ifdef MSRV32_WB_FWD_EN
  assign fwd_valid_out = pop && (head_rd != 5'd0);
  assign fwd_addr_out  = pop ? head_rd : 5'd0;
  assign fwd_data_out  = pop ? ld_rsp_data_in : 32'd0;
`else
  assign fwd_valid_out = 1'b0;
  assign fwd_addr_out  = 5'd0;
  assign fwd_data_out  = 32'd0;
`endif

endmodule

// File: tb/tb_msrv32_wb_port_arbiter.sv
// Directed scoreboard bench for msrv32_wb_port_arbiter (default and MSRV32_WB_FWD_EN builds).
module tb_msrv32_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pipe_wr_req;
  logic [4:0]  pipe_rd_addr;
  logic [31:0] pipe_wb_data;
  logic        pipe_stall;
  logic        ld_issue;
  logic [4:0]  ld_rd_addr;
  logic        ld_rsp_valid;
  logic [31:0] ld_rsp_data;
  logic        ld_full, ld_empty;
  logic [4:0]  rs1_addr, rs2_addr;
  logic        hazard;
  logic        rf_wr_en;
  logic [4:0]  rf_rd_addr;
  logic [31:0] rf_wr_data;
  logic        ld_overflow, ld_underflow;
  logic        fwd_valid;
  logic [4:0]  fwd_addr;
  logic [31:0] fwd_data;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        en;
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;
  wr_t exp_q[$];

  msrv32_wb_port_arbiter #(.LD_DEPTH(2)) dut (
    .ms_riscv32_mp_clk_in(clk),
    .ms_riscv32_mp_rst_in(rst),
    .pipe_wr_req_in(pipe_wr_req),
    .pipe_rd_addr_in(pipe_rd_addr),
    .pipe_wb_data_in(pipe_wb_data),
    .pipe_stall_out(pipe_stall),
    .ld_issue_in(ld_issue),
    .ld_rd_addr_in(ld_rd_addr),
    .ld_rsp_valid_in(ld_rsp_valid),
    .ld_rsp_data_in(ld_rsp_data),
    .ld_full_out(ld_full),
    .ld_empty_out(ld_empty),
    .rs1_addr_in(rs1_addr),
    .rs2_addr_in(rs2_addr),
    .hazard_out(hazard),
    .rf_wr_en_out(rf_wr_en),
    .rf_rd_addr_out(rf_rd_addr),
    .rf_wr_data_out(rf_wr_data),
    .ld_overflow_out(ld_overflow),
    .ld_underflow_out(ld_underflow),
    .fwd_valid_out(fwd_valid),
    .fwd_addr_out(fwd_addr),
    .fwd_data_out(fwd_data)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic idle();
    pipe_wr_req = 1'b0; pipe_rd_addr = 5'd0; pipe_wb_data = 32'd0;
    ld_issue = 1'b0; ld_rd_addr = 5'd0;
    ld_rsp_valid = 1'b0; ld_rsp_data = 32'd0;
    rs1_addr = 5'd0; rs2_addr = 5'd0;
  endtask

  task automatic expect_wr(input logic en, input logic [4:0] a, input logic [31:0] d);
    wr_t e;
    e.en = en; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endtask

  // Advance one clock and score the write port against the oldest expectation.
  task automatic tick(input string tag);
    wr_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_en"}, {31'd0, rf_wr_en}, {31'd0, e.en});
      if (e.en) begin
        chk({tag, "_addr"}, {27'd0, rf_rd_addr}, {27'd0, e.addr});
        chk({tag, "_data"}, rf_wr_data, e.data);
      end
    end
    idle();
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_wr_en"},  {31'd0, rf_wr_en},   32'd0);
    chk({tag, "_addr"},   {27'd0, rf_rd_addr}, 32'd0);
    chk({tag, "_data"},   rf_wr_data,          32'd0);
    chk({tag, "_stall"},  {31'd0, pipe_stall}, 32'd0);
    chk({tag, "_empty"},  {31'd0, ld_empty},   32'd1);
    chk({tag, "_full"},   {31'd0, ld_full},    32'd0);
    chk({tag, "_hazard"}, {31'd0, hazard},     32'd0);
    chk({tag, "_ovf"},    {31'd0, ld_overflow},  32'd0);
    chk({tag, "_udf"},    {31'd0, ld_underflow}, 32'd0);
    chk({tag, "_fwdv"},   {31'd0, fwd_valid},  32'd0);
    chk({tag, "_fwda"},   {27'd0, fwd_addr},   32'd0);
    chk({tag, "_fwdd"},   fwd_data,            32'd0);
  endtask

  initial begin
    idle();
    rst = 1'b1;
    #3;
    chk_reset_state("rst0");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Plain pipeline write.
    pipe_wr_req = 1'b1; pipe_rd_addr = 5'd5; pipe_wb_data = 32'h12345678;
    #1 chk("pipe_stall0", {31'd0, pipe_stall}, 32'd0);
    expect_wr(1'b1, 5'd5, 32'h12345678);
    tick("pipe5");
    chk("pipe_stall1", {31'd0, pipe_stall}, 32'd0);

    // Pipeline request collides with a load response -> skid.
    ld_issue = 1'b1; ld_rd_addr = 5'd7;
    expect_wr(1'b0, 5'd0, 32'd0);
    tick("issue7");
    pipe_wr_req = 1'b1; pipe_rd_addr = 5'd3; pipe_wb_data = 32'hABCDEFAB;
    ld_rsp_valid = 1'b1; ld_rsp_data = 32'h87654321;
    #1;
`ifdef MSRV32_WB_FWD_EN
    chk("fwd7_valid", {31'd0, fwd_valid}, 32'd1);
    chk("fwd7_addr",  {27'd0, fwd_addr},  32'd7);
    chk("fwd7_data",  fwd_data,           32'h87654321);
`else
    chk("fwd7_valid", {31'd0, fwd_valid}, 32'd0);
`endif
    expect_wr(1'b1, 5'd7, 32'h87654321);
    tick("rsp7");
    chk("skid_stall1", {31'd0, pipe_stall}, 32'd1);
    expect_wr(1'b1, 5'd3, 32'hABCDEFAB);
    tick("skid3");
    chk("skid_stall0", {31'd0, pipe_stall}, 32'd0);
    chk("empty_after7", {31'd0, ld_empty}, 32'd1);

    // Fill, overflow, drain.
    ld_issue = 1'b1; ld_rd_addr = 5'd1;
    expect_wr(1'b0, 5'd0, 32'd0);
    tick("issue1");
    ld_issue = 1'b1; ld_rd_addr = 5'd2;
    expect_wr(1'b0, 5'd0, 32'd0);
    tick("issue2");
    chk("full2", {31'd0, ld_full}, 32'd1);
    ld_issue = 1'b1; ld_rd_addr = 5'd9;
    expect_wr(1'b0, 5'd0, 32'd0);
    tick("issue_ovf");
    chk("ovf_flag", {31'd0, ld_overflow}, 32'd1);
    chk("full_ovf", {31'd0, ld_full}, 32'd1);
    ld_rsp_valid = 1'b1; ld_rsp_data = 32'h11;
    expect_wr(1'b1, 5'd1, 32'h11);
    tick("rsp1");
    ld_rsp_valid = 1'b1; ld_rsp_data = 32'h22;
    expect_wr(1'b1, 5'd2, 32'h22);
    tick("rsp2");
    chk("empty_drain", {31'd0, ld_empty}, 32'd1);

    // Hazard detection.
    ld_issue = 1'b1; ld_rd_addr = 5'd9; rs2_addr = 5'd9;
    #1 chk("hz_same_cycle_push", {31'd0, hazard}, 32'd0);
    expect_wr(1'b0, 5'd0, 32'd0);
    tick("issue9");
    rs2_addr = 5'd9;
    #1 chk("hz_rs2", {31'd0, hazard}, 32'd1);
    rs2_addr = 5'd0;
    #1 chk("hz_zero", {31'd0, hazard}, 32'd0);
    rs1_addr = 5'd9;
    #1 chk("hz_rs1", {31'd0, hazard}, 32'd1);
    rs1_addr = 5'd0; rs2_addr = 5'd9;
    ld_rsp_valid = 1'b1; ld_rsp_data = 32'h99;
    #1;
`ifdef MSRV32_WB_FWD_EN
    chk("hz_pop_cycle", {31'd0, hazard}, 32'd0);
`else
    chk("hz_pop_cycle", {31'd0, hazard}, 32'd1);
`endif
    expect_wr(1'b1, 5'd9, 32'h99);
    tick("rsp9");
    rs2_addr = 5'd9;
    #1 chk("hz_released", {31'd0, hazard}, 32'd0);

    // x0 and underflow.
    pipe_wr_req = 1'b1; pipe_rd_addr = 5'd0; pipe_wb_data = 32'hFFFFFFFF;
    expect_wr(1'b0, 5'd0, 32'd0);
    tick("x0");
    ld_rsp_valid = 1'b1; ld_rsp_data = 32'h55;
    expect_wr(1'b0, 5'd0, 32'd0);
    tick("udf_rsp");
    chk("udf_flag", {31'd0, ld_underflow}, 32'd1);

    // Response while skid is full: response wins, skid holds.
    ld_issue = 1'b1; ld_rd_addr = 5'd10;
    expect_wr(1'b0, 5'd0, 32'd0);
    tick("issue10");
    ld_issue = 1'b1; ld_rd_addr = 5'd11;
    expect_wr(1'b0, 5'd0, 32'd0);
    tick("issue11");
    pipe_wr_req = 1'b1; pipe_rd_addr = 5'd12; pipe_wb_data = 32'hC0C0C0C0;
    ld_rsp_valid = 1'b1; ld_rsp_data = 32'hA0A0A0A0;
    expect_wr(1'b1, 5'd10, 32'hA0A0A0A0);
    tick("rsp10");
    ld_rsp_valid = 1'b1; ld_rsp_data = 32'hB0B0B0B0;
    #1 chk("skid_hold_stall", {31'd0, pipe_stall}, 32'd1);
    expect_wr(1'b1, 5'd11, 32'hB0B0B0B0);
    tick("rsp11");
    chk("skid_still", {31'd0, pipe_stall}, 32'd1);
    expect_wr(1'b1, 5'd12, 32'hC0C0C0C0);
    tick("skid12");
    chk("skid_done", {31'd0, pipe_stall}, 32'd0);

    // Push+pop at full, skid loaded, then asynchronous reset.
    ld_issue = 1'b1; ld_rd_addr = 5'd13;
    expect_wr(1'b0, 5'd0, 32'd0);
    tick("issue13");
    ld_issue = 1'b1; ld_rd_addr = 5'd14;
    expect_wr(1'b0, 5'd0, 32'd0);
    tick("issue14");
    ld_issue = 1'b1; ld_rd_addr = 5'd15;
    ld_rsp_valid = 1'b1; ld_rsp_data = 32'hD0D0D0D0;
    pipe_wr_req = 1'b1; pipe_rd_addr = 5'd16; pipe_wb_data = 32'hE0E0E0E0;
    expect_wr(1'b1, 5'd13, 32'hD0D0D0D0);
    tick("pushpop13");
    chk("pushpop_full", {31'd0, ld_full}, 32'd1);
    chk("pushpop_stall", {31'd0, pipe_stall}, 32'd1);
    rs1_addr = 5'd14;
    #1 chk("hz_pre_rst", {31'd0, hazard}, 32'd1);
    rs1_addr = 5'd0;
    rst = 1'b1;
    #1 chk_reset_state("rst_mid");
    @(posedge clk); #1;
    rst = 1'b0;
    expect_wr(1'b0, 5'd0, 32'd0);
    tick("post_rst");
    chk("post_rst_empty", {31'd0, ld_empty}, 32'd1);

    // Load forwarding.
    ld_issue = 1'b1; ld_rd_addr = 5'd4;
    expect_wr(1'b0, 5'd0, 32'd0);
    tick("issue4");
    ld_rsp_valid = 1'b1; ld_rsp_data = 32'h98765432;
    #1;
`ifdef MSRV32_WB_FWD_EN
    chk("fwd4_valid", {31'd0, fwd_valid}, 32'd1);
    chk("fwd4_addr",  {27'd0, fwd_addr},  32'd4);
    chk("fwd4_data",  fwd_data,           32'h98765432);
`else
    chk("fwd4_valid", {31'd0, fwd_valid}, 32'd0);
    chk("fwd4_data",  fwd_data,           32'd0);
`endif
    expect_wr(1'b1, 5'd4, 32'h98765432);
    tick("rsp4");
    chk("fwd_idle", {31'd0, fwd_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
